// File: rtl/axis_capture_sequencer.sv
// ---------------------------------------------------------------------------
// axis_capture_sequencer
//
// Run-control front end for axis_ram_writer. It gates a free-running ADC
// AXIS stream into the writer for one run at a time:
//   IDLE -> RESET -> ARMED -> CAPTURE -> DRAIN -> DONE.
// The writer is held in reset while IDLE and for RST_CYCLES at the start of
// every run, so each run restarts at the writer's base address with empty
// FIFOs.
//
// Ports
//   aclk, areset     clock, synchronous active-high reset
//   cfg_start        rising edge starts a run (accepted in IDLE/DONE only)
//   cfg_abort        level, forces IDLE with priority over everything
//   cfg_trig_mode    0: capture as soon as armed, 1: wait for trig_in rise
//   cfg_length       words per run, low 4 bits ignored (16-beat bursts)
//   trig_in          external trigger, synchronous to aclk
//   sts_addr         writer beat counter, used to detect drain completion
//   s_axis_*         source stream (discarded while the gate is closed)
//   m_axis_*         stream to the writer, tdata passed straight through
//   m_rst            active-high reset to the writer
//   sts_state        0 IDLE, 1 RESET, 2 ARMED, 3 CAPTURE, 4 DRAIN, 5 DONE
//   sts_count        beats accepted this run
//   sts_done         high in DONE
//   sts_ovf          sticky: source valid while writer not ready in CAPTURE
// ---------------------------------------------------------------------------
module axis_capture_sequencer #(
    parameter int ADDR_WIDTH       = 16,
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int RST_CYCLES       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cfg_start,
    input  logic                        cfg_abort,
    input  logic                        cfg_trig_mode,
    input  logic [ADDR_WIDTH-1:0]       cfg_length,
    input  logic                        trig_in,
    input  logic [ADDR_WIDTH-1:0]       sts_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_rst,
    output logic [2:0]                  sts_state,
    output logic [ADDR_WIDTH-1:0]       sts_count,
    output logic                        sts_done,
    output logic                        sts_ovf
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESET   = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [2:0]            state, state_d;
    logic                  cfg_start_q, trig_q;
    logic                  start_rise, trig_rise;
    logic                  beat, last_beat, run_start, gate_open;
    logic [ADDR_WIDTH-1:0] len_eff, len_eff_q;
    logic [RCW-1:0]        rst_cnt;

    // Low length bits are dropped on purpose: runs are whole bursts.
    logic unused_len_lsbs;
    assign unused_len_lsbs = ^cfg_length[3:0];

    assign start_rise = cfg_start & ~cfg_start_q;
    assign trig_rise  = trig_in & ~trig_q;
    assign len_eff    = {cfg_length[ADDR_WIDTH-1:4], 4'b0};

    assign beat      = (state == S_CAPTURE) & s_axis_tvalid & m_axis_tready;
    // The beat that brings the count to len_eff is the last one passed; the
    // gate is a decode of state, so it is shut from the following cycle.
    assign last_beat = beat & ((sts_count + ADDR_WIDTH'(1)) == len_eff_q);

    // Taking the RESET state from anywhere else is the start of a new run.
    assign run_start = (state_d == S_RESET) && (state != S_RESET);

    assign sts_state    = state;
    assign m_axis_tdata = s_axis_tdata;

    // ---------------- state register ----------------
    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state;
        if (cfg_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start_rise) state_d = S_RESET;
                S_RESET:        if (rst_cnt == '0) state_d = S_ARMED;
                S_ARMED: begin
                    if (len_eff_q == '0)                state_d = S_DONE;
                    else if (!cfg_trig_mode || trig_rise) state_d = S_CAPTURE;
                end
                S_CAPTURE:      if (last_beat) state_d = S_DRAIN;
                S_DRAIN:        if (sts_addr == len_eff_q) state_d = S_DONE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- stream gate ----------------
    // Closed gate keeps the source drained (ready=1) and the writer idle.
    always_comb begin
        gate_open     = (state == S_CAPTURE);
        m_axis_tvalid = gate_open & s_axis_tvalid;
        s_axis_tready = gate_open ? m_axis_tready : 1'b1;
    end

    // ---------------- edge detect, counters, registered status ----------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            cfg_start_q <= 1'b0;
            trig_q      <= 1'b0;
            m_rst       <= 1'b1;
            sts_done    <= 1'b0;
            sts_count   <= '0;
            sts_ovf     <= 1'b0;
            len_eff_q   <= '0;
            rst_cnt     <= '0;
        end else begin
            cfg_start_q <= cfg_start;
            trig_q      <= trig_in;
            // Decoded from next state so m_rst drops on the RESET->ARMED edge
            // and rises on the edge that enters IDLE after an abort.
            m_rst       <= (state_d == S_IDLE) || (state_d == S_RESET);
            sts_done    <= (state_d == S_DONE);
            if (run_start) begin
                sts_count <= '0;
                sts_ovf   <= 1'b0;
                len_eff_q <= len_eff;
                rst_cnt   <= RCW'(RST_CYCLES - 1);
            end else begin
                if (state == S_RESET && rst_cnt != '0)
                    rst_cnt <= rst_cnt - RCW'(1);
                if (beat)
                    sts_count <= sts_count + ADDR_WIDTH'(1);
                if (state == S_CAPTURE && s_axis_tvalid && !m_axis_tready)
                    sts_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axis_capture_sequencer
//
// Directed bench: a table of runs {length, trigger mode, ready stall,
// expected beats, expected overflow} plus hand-written sequences for abort,
// mid-run reset and ignored start/trigger pulses. A writer stub models
// sts_addr as the burst-rounded beat count seen three cycles late.
// Inputs are driven on the falling edge, outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_axis_capture_sequencer;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESET   = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic        aclk = 1'b0;
    logic        areset, cfg_start, cfg_abort, cfg_trig_mode, trig_in;
    logic [15:0] cfg_length;
    logic [15:0] sts_addr;
    logic [63:0] s_axis_tdata, m_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
    logic        m_rst, sts_done, sts_ovf;
    logic [2:0]  sts_state;
    logic [15:0] sts_count;

    int checks = 0;
    int errors = 0;
    int tb_beats = 0;

    always #5 aclk = ~aclk;

    axis_capture_sequencer #(
        .ADDR_WIDTH(16), .AXIS_TDATA_WIDTH(64), .RST_CYCLES(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_trig_mode(cfg_trig_mode), .cfg_length(cfg_length),
        .trig_in(trig_in), .sts_addr(sts_addr),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_rst(m_rst), .sts_state(sts_state), .sts_count(sts_count),
        .sts_done(sts_done), .sts_ovf(sts_ovf)
    );

    // Writer stub: counts accepted beats, reports whole bursts with lag.
    logic [15:0] stub_beats = '0, p1 = '0, p2 = '0;
    initial sts_addr = '0;
    always @(posedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) tb_beats <= tb_beats + 1;
        if (m_rst) begin
            stub_beats <= '0; p1 <= '0; p2 <= '0; sts_addr <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) stub_beats <= stub_beats + 16'd1;
            p1       <= {stub_beats[15:4], 4'h0};
            p2       <= p1;
            sts_addr <= p2;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input string nm, input logic [2:0] st);
        for (int n = 0; n < 1000 && sts_state != st; n++) @(negedge aclk);
        chk(nm, sts_state, st);
    endtask

    // Pulse start, check the RESET phase, return at the first ARMED negedge.
    task automatic start_run(input logic [15:0] len, input logic mode, output int snap);
        int n;
        @(negedge aclk);
        cfg_length = len; cfg_trig_mode = mode; cfg_start = 1'b1;
        snap = tb_beats;
        @(negedge aclk);
        cfg_start = 1'b0;
        chk("start_state", sts_state, ST_RESET);
        chk("start_count", sts_count, 0);
        chk("start_ovf", sts_ovf, 0);
        n = 0;
        while (sts_state == ST_RESET && n < 100) begin
            if (m_rst) n++;
            @(negedge aclk);
        end
        chk("rst_len", n, 16);
        chk("armed_state", sts_state, ST_ARMED);
        chk("armed_mrst", m_rst, 0);
    endtask

    // Run capture to DONE (optional ready stall) and check the run result.
    task automatic finish_run(input string nm, input int exp, input logic exp_ovf,
                              input int snap, input int stall_at, input int stall_len);
        int   idx = 0;
        int   saved = 0;
        int   after;
        logic saw_drain = 1'b0;
        for (int c = 0; c < 2000 && sts_state != ST_DONE; c++) begin
            m_axis_tready = 1'b1;
            if (sts_state == ST_CAPTURE) begin
                if (idx == 1) begin
                    s_axis_tdata = {$urandom, $urandom};
                    #1 chk("tdata_pass", m_axis_tdata, s_axis_tdata);
                end
                if (stall_len > 0 && idx == stall_at) saved = sts_count;
                if (stall_len > 0 && idx == stall_at + stall_len)
                    chk("stall_nocount", sts_count, saved);
                if (stall_len > 0 && idx >= stall_at && idx < stall_at + stall_len)
                    m_axis_tready = 1'b0;
                idx++;
            end
            if (sts_state == ST_DRAIN) saw_drain = 1'b1;
            @(negedge aclk);
        end
        m_axis_tready = 1'b1;
        chk({nm, "_done_state"}, sts_state, ST_DONE);
        chk({nm, "_sts_done"}, sts_done, 1);
        chk({nm, "_count"}, sts_count, exp);
        chk({nm, "_beats"}, tb_beats - snap, exp);
        chk({nm, "_ovf"}, sts_ovf, exp_ovf);
        chk({nm, "_mrst"}, m_rst, 0);
        if (exp != 0) chk({nm, "_drain_seen"}, saw_drain, 1);
        // Source keeps streaming: nothing more may reach the writer.
        after = tb_beats;
        repeat (5) @(negedge aclk);
        chk({nm, "_no_extra"}, tb_beats, after);
        chk({nm, "_gate_tvalid"}, m_axis_tvalid, 0);
        chk({nm, "_gate_tready"}, s_axis_tready, 1);
        chk({nm, "_ovf_hold"}, sts_ovf, exp_ovf);
    endtask

    typedef struct {
        logic [15:0] len;
        logic        mode;
        int          stall_at;
        int          stall_len;
        int          exp_beats;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int snap;
        vecs[0] = '{16'h0040, 1'b0, 0, 0, 64, 1'b0};  // plain run
        vecs[1] = '{16'h0025, 1'b0, 0, 0, 32, 1'b0};  // low bits ignored
        vecs[2] = '{16'h000F, 1'b0, 0, 0,  0, 1'b0};  // rounds to zero
        vecs[3] = '{16'h0020, 1'b1, 0, 0, 32, 1'b0};  // triggered
        vecs[4] = '{16'h0030, 1'b0, 5, 3, 48, 1'b1};  // writer stall
        vecs[5] = '{16'h0010, 1'b0, 0, 0, 16, 1'b0};  // ovf cleared by start

        areset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_trig_mode = 1'b0;
        cfg_length = '0; trig_in = 1'b0; s_axis_tdata = 64'h0123_4567_89AB_CDEF;
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        chk("rst_state", sts_state, ST_IDLE);
        chk("rst_count", sts_count, 0);
        chk("rst_ovf", sts_ovf, 0);
        chk("rst_mrst", m_rst, 1);
        chk("rst_done", sts_done, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tready", s_axis_tready, 1);

        for (int i = 0; i < 6; i++) begin
            start_run(vecs[i].len, vecs[i].mode, snap);
            if (vecs[i].mode && vecs[i].exp_beats != 0) begin
                for (int c = 0; c < 100; c++) begin
                    chk("wait_armed", sts_state, ST_ARMED);
                    chk("wait_tvalid", m_axis_tvalid, 0);
                    chk("wait_tready", s_axis_tready, 1);
                    @(negedge aclk);
                end
                trig_in = 1'b1;
                @(negedge aclk);
                trig_in = 1'b0;
                chk("trig_capture", sts_state, ST_CAPTURE);
            end
            finish_run($sformatf("vec%0d", i), vecs[i].exp_beats, vecs[i].exp_ovf,
                       snap, vecs[i].stall_at, vecs[i].stall_len);
        end

        // Abort after 20 beats, start ignored under abort, clean restart.
        start_run(16'h0040, 1'b0, snap);
        for (int n = 0; n < 500 && !(sts_state == ST_CAPTURE && sts_count == 20); n++)
            @(negedge aclk);
        chk("abort_at20", sts_count, 20);
        s_axis_tvalid = 1'b0; cfg_abort = 1'b1;
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        #1;
        chk("abort_state", sts_state, ST_IDLE);
        chk("abort_mrst", m_rst, 1);
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_tready", s_axis_tready, 1);
        cfg_start = 1'b1;
        @(negedge aclk);
        chk("abort_start_ign", sts_state, ST_IDLE);
        cfg_start = 1'b0; cfg_abort = 1'b0;
        @(negedge aclk);
        chk("abort_idle", sts_state, ST_IDLE);
        start_run(16'h0040, 1'b0, snap);
        finish_run("restart", 64, 1'b0, snap, 0, 0);

        // Start during CAPTURE and trigger during DRAIN are ignored.
        start_run(16'h0040, 1'b0, snap);
        for (int n = 0; n < 500 && !(sts_state == ST_CAPTURE && sts_count == 10); n++)
            @(negedge aclk);
        cfg_start = 1'b1;
        @(negedge aclk);
        cfg_start = 1'b0;
        chk("ign_start_state", sts_state, ST_CAPTURE);
        chk("ign_start_count", sts_count, 11);
        wait_state("ign_drain_reach", ST_DRAIN);
        trig_in = 1'b1;
        @(negedge aclk);
        trig_in = 1'b0;
        chk("ign_trig_state", sts_state, ST_DRAIN);
        chk("ign_trig_count", sts_count, 64);
        wait_state("ign_done_reach", ST_DONE);
        chk("ign_final_count", sts_count, 64);
        chk("ign_final_beats", tb_beats - snap, 64);

        // Reset in the middle of a capture.
        start_run(16'h0040, 1'b0, snap);
        repeat (6) @(negedge aclk);
        chk("midrst_capture", sts_state, ST_CAPTURE);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        chk("midrst_state", sts_state, ST_IDLE);
        chk("midrst_count", sts_count, 0);
        chk("midrst_mrst", m_rst, 1);
        chk("midrst_done", sts_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
